sram_banked_2p: RTL and testbench
=================================

# sram_banked_2p

Two-port, multi-bank inferred SRAM for the SAURIA core: the parametrised successor of the single-port inferred RAM. It is generalised in width, depth and bank count, with true byte-enable writes and a configurable read latency. Two requestors share NUM_BANKS word-interleaved banks. Bank conflicts are resolved by a round-robin grant, and each port has its own read-return pipeline with a valid strobe. It sits between the feeder/DMA side and the array-side data fetchers.

## Interface
- ADR_W, 10, word address width seen by each port (total depth 2**ADR_W words)
- SRAM_W, 128, word width in bits; multiple of 8
- NUM_BANKS, 4, bank count; power of two, 1..2**ADR_W; bank = addr[log2(NUM_BANKS)-1:0], row = remaining upper bits
- RD_LAT, 1, read latency in cycles from grant to o_rvalid; legal 1..3
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous and active-high
- i_req  in  2  per-port request valid
- i_wen  in  2  per-port 1 = write, 0 = read (qualified by i_req)
- i_addr  in  2 x ADR_W  per-port word address
- i_wdata  in  2 x SRAM_W  per-port write data
- i_bmask  in  2 x SRAM_W/8  per-port byte enable; bit b writes bits [8b+7:8b]
- o_gnt  out  2  per-port grant; request accepted this cycle when i_req & o_gnt
- o_rvalid  out  2  per-port read-data valid strobe
- o_rdata  out  2 x SRAM_W  per-port read data

## Operation
- Conflict: i_req[0] & i_req[1] and both ports address the same bank. Read/write type is irrelevant.
- No conflict: every requesting port is granted.
- Conflict: the port selected by the priority bit `prio` is granted and the other is not. After a conflict, `prio` flips to the losing port. `prio` is unchanged in cycles without a conflict.
- o_gnt is combinational from i_req, i_addr and `prio`. o_gnt[p] = 0 whenever i_req[p] = 0.
- A non-granted requestor must hold i_req, i_wen, i_addr, i_wdata and i_bmask stable until granted. The block stores no pending request.
- Granted write: at the edge, only bytes with i_bmask[b]=1 at bank/row are updated. All-zero mask: no memory change, but the request is still granted and occupies the bank. No o_rvalid is produced.
- Granted read: the row is read at the edge and returned through that port's own RD_LAT-stage pipeline. The pipeline tags the data with valid only; no bank or ID is returned.
- Same-port write then read of the same address on the next cycle returns the new data. The same address in the same cycle on both ports is impossible, because it is a bank conflict.
- o_rdata[p] holds the last returned word until the next o_rvalid[p]. It is meaningful only while o_rvalid[p]=1.
- NUM_BANKS=1: every dual request conflicts, so the block degenerates to an arbitrated single-bank RAM.
- Memory contents are not reset, and X until written.

## Timing
- Reset (i_rst=1 at an edge): `prio`=0, all o_rvalid=0, all o_rdata=0, read pipelines flushed. Reads in flight are discarded. Writes granted in the reset cycle are ignored.
- o_gnt is low for the whole cycle while i_rst=1.
- Read granted at edge t: o_rvalid[p]=1 and o_rdata[p] valid in the cycle after edge t+RD_LAT-1. RD_LAT=1 means data appears immediately after the grant edge.
- Throughput: one access per port per cycle, with back-to-back reads fully pipelined. There is no backpressure on the return path; the consumer must always accept.
- Persistent conflict: each port is granted every other cycle (bounded wait of 1 cycle).
- Returns per port are in request order.

## Test plan
- Reset, then port 0 writes 0xA5.. (all bytes) to addr 0x004, then reads it with RD_LAT=1 -> o_rvalid[0] one cycle after the read grant, o_rdata[0]=0xA5..; o_rvalid[1] stays 0.
- Byte mask: write all-0xFF to addr 8, then write 0x00 with i_bmask=16'h0001, then read -> low byte 0x00, all other bytes 0xFF.
- Both ports read different banks (addr 0 and 1, NUM_BANKS=4) for 8 cycles -> o_gnt=2'b11 every cycle, both ports get 8 consecutive o_rvalid pulses in order.
- Both ports hold requests to bank 2 (addr 2 and 6) -> grants alternate port0, port1, port0... starting from port 0 after reset; each port's data returns correctly.
- RD_LAT=3, port 1 reads 4 addresses back-to-back, then i_rst asserted on the cycle after the last grant -> no o_rvalid after reset; o_rdata=0, `prio`=0.
- NUM_BANKS=1, port 0 writes addr 3 while port 1 reads addr 3 -> only port 0 granted first; port 1 is granted next cycle and reads the new data.

Source files
------------

// File: rtl/sram_banked_2p.sv
// Two-port, word-interleaved multi-bank SRAM with round-robin bank arbitration,
// byte-enable writes and a per-port read-return pipeline of RD_LAT stages.
module sram_banked_2p #(
   parameter int unsigned ADR_W     = 10,
   parameter int unsigned SRAM_W    = 128,
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [1:0]                 i_req,
   input  logic [1:0]                 i_wen,
   input  logic [1:0][ADR_W-1:0]      i_addr,
   input  logic [1:0][SRAM_W-1:0]     i_wdata,
   input  logic [1:0][SRAM_W/8-1:0]   i_bmask,
   output logic [1:0]                 o_gnt,
   output logic [1:0]                 o_rvalid,
   output logic [1:0][SRAM_W-1:0]     o_rdata
);

   localparam int unsigned BANK_LG = $clog2(NUM_BANKS);
   localparam int unsigned BANK_W  = (BANK_LG == 0) ? 1 : BANK_LG;
   localparam int unsigned ROW_W   = ADR_W - BANK_LG;
   localparam int unsigned ROWS    = 2 ** ROW_W;
   localparam int unsigned NBYTES  = SRAM_W / 8;
   localparam int          LAT     = int'(RD_LAT);

   logic [1:0][BANK_W-1:0]  bankSel;
   logic [1:0][ROW_W-1:0]   rowSel;
   logic [1:0][SRAM_W-1:0]  rdWord;
   logic [SRAM_W-1:0]       bankRd [NUM_BANKS];

   logic       conflict;
   logic [1:0] gnt;
   logic [1:0] wrFire;
   logic [1:0] rdFire;
   logic       prio_q, prio_d;

   logic [1:0][LAT-1:0]             vld_q;
   logic [1:0][LAT-1:0][SRAM_W-1:0] dat_q;

   // Low address bits pick the bank so consecutive words land in different banks.
   generate
      if (BANK_LG == 0) begin : gSingle
         assign bankSel   = '0;
         assign rowSel    = i_addr;
         assign rdWord[0] = bankRd[0];
         assign rdWord[1] = bankRd[0];
      end else begin : gMulti
         for (genvar p = 0; p < 2; p++) begin : gPort
            assign bankSel[p] = i_addr[p][BANK_LG-1:0];
            assign rowSel[p]  = i_addr[p][ADR_W-1:BANK_LG];
            assign rdWord[p]  = bankRd[bankSel[p]];
         end
      end
   endgenerate

   always_comb begin
      conflict = i_req[0] & i_req[1] & (bankSel[0] == bankSel[1]);
      gnt      = '0;
      prio_d   = prio_q;
      if (!i_rst) begin
         if (conflict) begin
            gnt[prio_q] = 1'b1;
            prio_d      = ~prio_q;
         end else begin
            gnt = i_req;
         end
      end
   end

   assign wrFire = gnt & i_wen;
   assign rdFire = gnt & ~i_wen;
   assign o_gnt  = gnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

   // At most one granted port can target a given bank, so each bank has one access per cycle.
   generate
      for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
         logic [SRAM_W-1:0] mem_q [ROWS];
         logic [ROW_W-1:0]  rdRow;

         always_comb begin
            rdRow = rowSel[0];
            if (rdFire[1] && (bankSel[1] == BANK_W'(b))) begin
               rdRow = rowSel[1];
            end
         end

         assign bankRd[b] = mem_q[rdRow];

         always_ff @(posedge i_clk) begin
            for (int p = 0; p < 2; p++) begin
               for (int i = 0; i < int'(NBYTES); i++) begin
                  if (wrFire[p] && (bankSel[p] == BANK_W'(b)) && i_bmask[p][i]) begin
                     mem_q[rowSel[p]][8*i +: 8] <= i_wdata[p][8*i +: 8];
                  end
               end
            end
         end
      end
   endgenerate

   // Data stages only load on a valid beat, so the last stage holds the last returned word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            vld_q[p][0] <= rdFire[p];
            if (rdFire[p]) begin
               dat_q[p][0] <= rdWord[p];
            end
            for (int k = 1; k < LAT; k++) begin
               vld_q[p][k] <= vld_q[p][k-1];
               if (vld_q[p][k-1]) begin
                  dat_q[p][k] <= dat_q[p][k-1];
               end
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         o_rvalid[p] = vld_q[p][LAT-1];
         o_rdata[p]  = dat_q[p][LAT-1];
      end
   end

endmodule

// File: tb/tb_sram_banked_2p.sv
// Directed bench for sram_banked_2p: three instances (default, RD_LAT=3, single bank)
// share one stimulus bus; each scenario task checks the instance it targets.
module tb_sram_banked_2p;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          req, wen;
   logic [1:0][9:0]     addr;
   logic [1:0][127:0]   wdata;
   logic [1:0][15:0]    bmask;

   logic [1:0]          gntA, rvA, gntB, rvB, gntC, rvC;
   logic [1:0][127:0]   rdA, rdB, rdC;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_banked_2p #(.ADR_W(10), .SRAM_W(128), .NUM_BANKS(4), .RD_LAT(1)) dutA (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_wen(wen), .i_addr(addr),
      .i_wdata(wdata), .i_bmask(bmask), .o_gnt(gntA), .o_rvalid(rvA), .o_rdata(rdA));

   sram_banked_2p #(.ADR_W(10), .SRAM_W(128), .NUM_BANKS(4), .RD_LAT(3)) dutB (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_wen(wen), .i_addr(addr),
      .i_wdata(wdata), .i_bmask(bmask), .o_gnt(gntB), .o_rvalid(rvB), .o_rdata(rdB));

   sram_banked_2p #(.ADR_W(10), .SRAM_W(128), .NUM_BANKS(1), .RD_LAT(1)) dutC (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_wen(wen), .i_addr(addr),
      .i_wdata(wdata), .i_bmask(bmask), .o_gnt(gntC), .o_rvalid(rvC), .o_rdata(rdC));

   function automatic logic [127:0] pat(input int p, input int i);
      logic [31:0] w;
      w = 32'hC000_0000 + 32'(p << 8) + 32'(i);
      return {4{w}};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int p, input logic r, input logic w, input logic [9:0] a,
                                input logic [127:0] d, input logic [15:0] m);
      req[p]   = r;
      wen[p]   = w;
      addr[p]  = a;
      wdata[p] = d;
      bmask[p] = m;
   endtask

   task automatic idleAll;
      applyStimulus(0, 1'b0, 1'b0, 10'd0, '0, '0);
      applyStimulus(1, 1'b0, 1'b0, 10'd0, '0, '0);
   endtask

   task automatic doReset;
      idleAll();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      applyStimulus(0, 1'b1, 1'b0, 10'd0, '0, '0);
      applyStimulus(1, 1'b1, 1'b0, 10'd1, '0, '0);
      #1;
      checks++;
      if (gntA !== 2'b00 || gntB !== 2'b00 || gntC !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_gnt got %b/%b/%b exp 00", gntA, gntB, gntC);
      end
      tick();
      checks++;
      if (rvA !== 2'b00 || rvB !== 2'b00 || rvC !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_rvalid got %b/%b/%b exp 00", rvA, rvB, rvC);
      end
      checks++;
      if (rdA !== '0 || rdB !== '0 || rdC !== '0) begin
         errors++;
         $display("[TB] FAIL reset_rdata got %h exp 0", rdA[0]);
      end
      rst = 1'b0;
      idleAll();
   endtask

   task automatic test_write_read;
      logic [127:0] expv;
      expv = {16{8'hA5}};
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 10'h004, expv, 16'hFFFF);
      #1;
      checks++;
      if (gntA !== 2'b01) begin
         errors++;
         $display("[TB] FAIL wr_gnt got %b exp 01", gntA);
      end
      tick();
      applyStimulus(0, 1'b1, 1'b0, 10'h004, '0, '0);
      tick();
      idleAll();
      checks++;
      if (rvA !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rd_rvalid got %b exp 01", rvA);
      end
      checks++;
      if (rdA[0] !== expv) begin
         errors++;
         $display("[TB] FAIL rd_data got %h exp %h", rdA[0], expv);
      end
      tick();
      checks++;
      if (rvA !== 2'b00 || rdA[0] !== expv) begin
         errors++;
         $display("[TB] FAIL rd_hold got %b %h exp 00 %h", rvA, rdA[0], expv);
      end
   endtask

   task automatic test_byte_mask;
      logic [127:0] expv;
      expv = {16{8'hFF}};
      expv[7:0] = 8'h00;
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 10'd8, {16{8'hFF}}, 16'hFFFF);
      tick();
      applyStimulus(0, 1'b1, 1'b1, 10'd8, '0, 16'h0001);
      tick();
      applyStimulus(0, 1'b1, 1'b1, 10'd8, {16{8'h11}}, 16'h0000);
      #1;
      checks++;
      if (gntA !== 2'b01) begin
         errors++;
         $display("[TB] FAIL zero_mask_gnt got %b exp 01", gntA);
      end
      tick();
      checks++;
      if (rvA !== 2'b00) begin
         errors++;
         $display("[TB] FAIL write_no_rvalid got %b exp 00", rvA);
      end
      applyStimulus(0, 1'b1, 1'b0, 10'd8, '0, '0);
      tick();
      idleAll();
      checks++;
      if (rvA[0] !== 1'b1 || rdA[0] !== expv) begin
         errors++;
         $display("[TB] FAIL bmask_data got %b %h exp 1 %h", rvA[0], rdA[0], expv);
      end
   endtask

   task automatic test_parallel;
      int pulses;
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b1, 1'b1, 10'(4*i), pat(0, i), 16'hFFFF);
         applyStimulus(1, 1'b1, 1'b1, 10'(4*i+1), pat(1, i), 16'hFFFF);
         #1;
         checks++;
         if (gntA !== 2'b11) begin
            errors++;
            $display("[TB] FAIL par_wr_gnt[%0d] got %b exp 11", i, gntA);
         end
         tick();
      end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b1, 1'b0, 10'(4*i), '0, '0);
         applyStimulus(1, 1'b1, 1'b0, 10'(4*i+1), '0, '0);
         #1;
         checks++;
         if (gntA !== 2'b11) begin
            errors++;
            $display("[TB] FAIL par_rd_gnt[%0d] got %b exp 11", i, gntA);
         end
         tick();
         if (rvA == 2'b11) pulses++;
         checks++;
         if (rdA[0] !== pat(0, i) || rdA[1] !== pat(1, i)) begin
            errors++;
            $display("[TB] FAIL par_rd_data[%0d] got %h %h exp %h %h", i, rdA[0], rdA[1],
                     pat(0, i), pat(1, i));
         end
      end
      idleAll();
      checks++;
      if (pulses != 8) begin
         errors++;
         $display("[TB] FAIL par_pulses got %0d exp 8", pulses);
      end
      tick();
      checks++;
      if (rvA !== 2'b00) begin
         errors++;
         $display("[TB] FAIL par_idle got %b exp 00", rvA);
      end
   endtask

   task automatic test_conflict;
      logic [1:0] expG;
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 10'd2, pat(2, 0), 16'hFFFF);
      tick();
      applyStimulus(0, 1'b1, 1'b1, 10'd6, pat(3, 0), 16'hFFFF);
      tick();
      applyStimulus(0, 1'b1, 1'b0, 10'd2, '0, '0);
      applyStimulus(1, 1'b1, 1'b0, 10'd6, '0, '0);
      for (int k = 0; k < 4; k++) begin
         expG = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         checks++;
         if (gntA !== expG) begin
            errors++;
            $display("[TB] FAIL conf_gnt[%0d] got %b exp %b", k, gntA, expG);
         end
         tick();
         checks++;
         if (rvA !== expG) begin
            errors++;
            $display("[TB] FAIL conf_rvalid[%0d] got %b exp %b", k, rvA, expG);
         end
         checks++;
         if ((expG[0] && rdA[0] !== pat(2, 0)) || (expG[1] && rdA[1] !== pat(3, 0))) begin
            errors++;
            $display("[TB] FAIL conf_data[%0d] got %h %h", k, rdA[0], rdA[1]);
         end
      end
      idleAll();
   endtask

   task automatic test_rdlat3_reset;
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1'b1, 1'b1, 10'(20+i), pat(4, i), 16'hFFFF);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1'b1, 1'b0, 10'(20+i), '0, '0);
         #1;
         checks++;
         if (gntB !== 2'b10) begin
            errors++;
            $display("[TB] FAIL lat3_gnt[%0d] got %b exp 10", i, gntB);
         end
         tick();
         checks++;
         if (rvB[1] !== (i >= 2)) begin
            errors++;
            $display("[TB] FAIL lat3_rvalid[%0d] got %b exp %b", i, rvB[1], (i >= 2));
         end
         if (i >= 2) begin
            checks++;
            if (rdB[1] !== pat(4, i-2)) begin
               errors++;
               $display("[TB] FAIL lat3_data[%0d] got %h exp %h", i, rdB[1], pat(4, i-2));
            end
         end
      end
      idleAll();
      rst = 1'b1;
      #1;
      checks++;
      if (rvB[1] !== 1'b1 || rdB[1] !== pat(4, 1)) begin
         errors++;
         $display("[TB] FAIL lat3_pre_rst got %b %h exp 1 %h", rvB[1], rdB[1], pat(4, 1));
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rvB !== 2'b00 || rdB !== '0) begin
            errors++;
            $display("[TB] FAIL lat3_flush[%0d] got %b %h exp 00 0", c, rvB, rdB[1]);
         end
         tick();
      end
      applyStimulus(0, 1'b1, 1'b0, 10'd20, '0, '0);
      applyStimulus(1, 1'b1, 1'b0, 10'd24, '0, '0);
      #1;
      checks++;
      if (gntB !== 2'b01) begin
         errors++;
         $display("[TB] FAIL lat3_prio got %b exp 01", gntB);
      end
      idleAll();
      tick();
   endtask

   task automatic test_single_bank;
      logic [127:0] w;
      w = pat(5, 7);
      doReset();
      applyStimulus(0, 1'b1, 1'b1, 10'd3, w, 16'hFFFF);
      applyStimulus(1, 1'b1, 1'b0, 10'd3, '0, '0);
      #1;
      checks++;
      if (gntC !== 2'b01) begin
         errors++;
         $display("[TB] FAIL sb_gnt0 got %b exp 01", gntC);
      end
      tick();
      applyStimulus(0, 1'b1, 1'b0, 10'd5, '0, '0);
      #1;
      checks++;
      if (gntC !== 2'b10) begin
         errors++;
         $display("[TB] FAIL sb_gnt1 got %b exp 10", gntC);
      end
      tick();
      applyStimulus(1, 1'b0, 1'b0, 10'd0, '0, '0);
      checks++;
      if (rvC !== 2'b10 || rdC[1] !== w) begin
         errors++;
         $display("[TB] FAIL sb_read got %b %h exp 10 %h", rvC, rdC[1], w);
      end
      #1;
      checks++;
      if (gntC !== 2'b01) begin
         errors++;
         $display("[TB] FAIL sb_gnt2 got %b exp 01", gntC);
      end
      idleAll();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      idleAll();
      tick();
      test_reset();
      test_write_read();
      test_byte_mask();
      test_parallel();
      test_conflict();
      test_rdlat3_reset();
      test_single_bank();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
